// File: rtl/fp_add_pkg.sv
// rtl/fp_add_pkg.sv - shared widths, operand class, flag layout and qNaN encoding for fp_add_pipe
package fp_add_pkg;

    localparam int EXP_W_DEF = 8;
    localparam int MAN_W_DEF = 23;

    function automatic int fp_word_w(input int exp_w, input int man_w);
        return 1 + exp_w + man_w;
    endfunction

    // hidden + fraction + guard + round + sticky
    function automatic int fp_work_w(input int man_w);
        return man_w + 4;
    endfunction

    function automatic int fp_bias(input int exp_w);
        return (1 << (exp_w - 1)) - 1;
    endfunction

    typedef enum logic [2:0] {
        CLS_ZERO,
        CLS_SUB,
        CLS_NORM,
        CLS_INF,
        CLS_NAN
    } fp_class_t;

    typedef struct packed {
        logic invalid;
        logic overflow;
        logic underflow;
        logic inexact;
        logic zero;
    } fp_flags_t;

    function automatic logic [63:0] fp_qnan(input int exp_w, input int man_w);
        logic [63:0] v;
        v = '0;
        for (int i = 0; i < exp_w; i++) v[man_w + i] = 1'b1;
        v[man_w - 1] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/fp_lzc.sv
// rtl/fp_lzc.sv - leading-zero counter; an all-zero input returns IN_W
module fp_lzc #(
    parameter  int IN_W  = 27,
    localparam int CNT_W = $clog2(IN_W) + 1
) (
    input  logic [IN_W-1:0]  i_data,
    output logic [CNT_W-1:0] o_count
);

    // Scanning upward lets the highest set bit win.
    always_comb begin
        o_count = CNT_W'(IN_W);
        for (int i = 0; i < IN_W; i++) begin
            if (i_data[i]) o_count = CNT_W'(IN_W - 1 - i);
        end
    end

endmodule

// File: rtl/fp_add_pipe.sv
// rtl/fp_add_pipe.sv - pipelined IEEE-754 add/sub, RNE, valid/ready; FP_ADD_PIPE_DENORM_EN selects gradual underflow
module fp_add_pipe
    import fp_add_pkg::*;
#(
    parameter int EXP_W = EXP_W_DEF,
    parameter int MAN_W = MAN_W_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [EXP_W+MAN_W:0]     a,
    input  logic [EXP_W+MAN_W:0]     b,
    input  logic                     sub,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [EXP_W+MAN_W:0]     s,
    output logic [4:0]               flags
);

    localparam int W    = fp_word_w(EXP_W, MAN_W);
    localparam int WW   = fp_work_w(MAN_W);
    localparam int LZ_W = $clog2(WW) + 1;
    localparam int XW   = EXP_W + 2;
    localparam logic [W-1:0]     QNAN    = W'(fp_qnan(EXP_W, MAN_W));
    localparam logic [EXP_W-1:0] EXP_MAX = '1;

    function automatic fp_class_t classify(input logic [EXP_W-1:0] e, input logic [MAN_W-1:0] f);
        if (e == '1) return (f == '0) ? CLS_INF : CLS_NAN;
        if (e == '0) return (f == '0) ? CLS_ZERO : CLS_SUB;
        return CLS_NORM;
    endfunction

    function automatic logic [MAN_W:0] signif(input logic [EXP_W-1:0] e, input logic [MAN_W-1:0] f);
`ifdef FP_ADD_PIPE_DENORM_EN
        return {e != '0, f};
`else
        return (e != '0) ? {1'b1, f} : '0;
`endif
    endfunction

    function automatic logic [EXP_W-1:0] eff_exp(input logic [EXP_W-1:0] e);
        return (e == '0) ? EXP_W'(1) : e;
    endfunction

    logic w_adv;
    assign w_adv    = !out_valid || out_ready;
    assign in_ready = w_adv;

    // ---------------- stage 1: unpack / align ----------------
    logic             w_sa, w_sb, w_swap, w_s_big;
    fp_class_t        w_ca, w_cb;
    logic [EXP_W-1:0] w_ea, w_eb, w_e_big, w_e_small, w_d;
    logic [MAN_W:0]   w_ma, w_mb, w_m_big, w_m_small;
    logic [WW-1:0]    w_ext, w_m_al;
    logic             w_lost;
    logic             w_spec;
    logic [W-1:0]     w_spec_s;
    fp_flags_t        w_spec_f;

    assign w_sa      = a[W-1];
    assign w_sb      = b[W-1] ^ sub;
    assign w_ca      = classify(a[W-2:MAN_W], a[MAN_W-1:0]);
    assign w_cb      = classify(b[W-2:MAN_W], b[MAN_W-1:0]);
    assign w_ea      = eff_exp(a[W-2:MAN_W]);
    assign w_eb      = eff_exp(b[W-2:MAN_W]);
    assign w_ma      = signif(a[W-2:MAN_W], a[MAN_W-1:0]);
    assign w_mb      = signif(b[W-2:MAN_W], b[MAN_W-1:0]);
    assign w_swap    = {w_eb, w_mb} > {w_ea, w_ma};
    assign w_s_big   = w_swap ? w_sb : w_sa;
    assign w_e_big   = w_swap ? w_eb : w_ea;
    assign w_e_small = w_swap ? w_ea : w_eb;
    assign w_m_big   = w_swap ? w_mb : w_ma;
    assign w_m_small = w_swap ? w_ma : w_mb;
    assign w_d       = w_e_big - w_e_small;
    assign w_ext     = {w_m_small, 3'b000};

    always_comb begin
        w_lost = 1'b0;
        w_m_al = '0;
        if (int'(w_d) >= MAN_W + 3) begin
            w_m_al = {{(WW-1){1'b0}}, |w_m_small};
        end else begin
            w_m_al = w_ext >> w_d;
            for (int i = 0; i < WW; i++) begin
                if (i < int'(w_d)) w_lost = w_lost | w_ext[i];
            end
            w_m_al[0] = w_m_al[0] | w_lost;
        end
    end

    always_comb begin
        w_spec   = 1'b1;
        w_spec_s = QNAN;
        w_spec_f = '0;
        if (w_ca == CLS_NAN || w_cb == CLS_NAN) begin
            w_spec_s = QNAN;
        end else if (w_ca == CLS_INF && w_cb == CLS_INF && w_sa != w_sb) begin
            w_spec_f.invalid = 1'b1;
        end else if (w_ca == CLS_INF) begin
            w_spec_s = {w_sa, EXP_MAX, {MAN_W{1'b0}}};
        end else if (w_cb == CLS_INF) begin
            w_spec_s = {w_sb, EXP_MAX, {MAN_W{1'b0}}};
        end else begin
            w_spec = 1'b0;
        end
    end

    logic             r1_valid, r1_spec, r1_sign, r1_eff_sub, r1_both_neg;
    logic [W-1:0]     r1_spec_s;
    fp_flags_t        r1_spec_f;
    logic [EXP_W-1:0] r1_exp;
    logic [WW-1:0]    r1_mb, r1_ms;

    // ---------------- stage 2: magnitude add ----------------
    logic [WW:0] w_sum;
    assign w_sum = r1_eff_sub ? ({1'b0, r1_mb} - {1'b0, r1_ms}) : ({1'b0, r1_mb} + {1'b0, r1_ms});

    logic             r2_valid, r2_spec, r2_sign;
    logic [W-1:0]     r2_spec_s;
    fp_flags_t        r2_spec_f;
    logic [EXP_W-1:0] r2_exp;
    logic [WW:0]      r2_sum;

    // ---------------- stage 3a: normalise ----------------
    logic [LZ_W-1:0] w_lz;
    logic [WW-1:0]   w_n_mant;
    logic [XW-1:0]   w_n_exp;
    logic            w_n_ftz;
    int              w_sh;

    fp_lzc #(.IN_W(WW)) u_lzc (
        .i_data  (r2_sum[WW-1:0]),
        .o_count (w_lz)
    );

    always_comb begin
        w_n_mant = '0;
        w_n_exp  = '0;
        w_n_ftz  = 1'b0;
        w_sh     = 0;
        if (r2_sum[WW]) begin
            w_n_mant = {r2_sum[WW:2], r2_sum[1] | r2_sum[0]};
            w_n_exp  = XW'(r2_exp) + XW'(1);
        end else if (r2_sum != '0) begin
`ifdef FP_ADD_PIPE_DENORM_EN
            // Stop at exponent 1; whatever shift is left over becomes a subnormal.
            w_sh = (int'(w_lz) < int'(r2_exp) - 1) ? int'(w_lz) : int'(r2_exp) - 1;
`else
            w_sh    = int'(w_lz);
            w_n_ftz = (int'(r2_exp) - w_sh) < 1;
`endif
            w_n_mant = r2_sum[WW-1:0] << w_sh;
            w_n_exp  = XW'(int'(r2_exp) - w_sh);
        end
    end

    logic          r3_valid, r3_spec, r3_sign, r3_ftz;
    logic [W-1:0]  r3_spec_s;
    fp_flags_t     r3_spec_f;
    logic [XW-1:0] r3_exp;
    logic [WW-1:0] r3_mant;

    // ---------------- stage 3b: round / pack ----------------
    logic             w_rnd, w_inexact, w_hidden;
    logic [MAN_W+1:0] w_sig;
    logic [MAN_W-1:0] w_frac;
    logic [XW-1:0]    w_exp_r;
    logic [W-1:0]     w_res;
    fp_flags_t        w_flg;

    always_comb begin
        w_rnd     = r3_mant[2] & (r3_mant[1] | r3_mant[0] | r3_mant[3]);
        w_inexact = |r3_mant[2:0];
        w_sig     = {1'b0, r3_mant[WW-1:3]} + {{(MAN_W+1){1'b0}}, w_rnd};
        w_hidden  = w_sig[MAN_W+1] | w_sig[MAN_W];
        if (w_sig[MAN_W+1]) begin
            w_exp_r = r3_exp + XW'(1);
            w_frac  = w_sig[MAN_W:1];
        end else begin
            w_exp_r = r3_exp;
            w_frac  = w_sig[MAN_W-1:0];
        end
        w_flg           = '0;
        w_flg.inexact   = w_inexact;
        w_flg.underflow = w_inexact & ~w_hidden;
        w_res = {r3_sign, (w_hidden ? w_exp_r[EXP_W-1:0] : {EXP_W{1'b0}}), w_frac};
        if (r3_spec) begin
            w_res = r3_spec_s;
            w_flg = r3_spec_f;
        end else if (r3_ftz) begin
            w_res           = {r3_sign, {(W-1){1'b0}}};
            w_flg.underflow = 1'b1;
            w_flg.inexact   = 1'b1;
        end else if (w_hidden && w_exp_r >= XW'(EXP_MAX)) begin
            w_res          = {r3_sign, EXP_MAX, {MAN_W{1'b0}}};
            w_flg.overflow = 1'b1;
            w_flg.inexact  = 1'b1;
        end
        w_flg.zero = (w_res[W-2:0] == '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r1_valid  <= 1'b0;
            r2_valid  <= 1'b0;
            r3_valid  <= 1'b0;
            out_valid <= 1'b0;
            s         <= '0;
            flags     <= '0;
        end else if (w_adv) begin
            r1_valid  <= in_valid;
            r2_valid  <= r1_valid;
            r3_valid  <= r2_valid;
            out_valid <= r3_valid;
            if (r3_valid) begin
                s     <= w_res;
                flags <= w_flg;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_adv) begin
            r1_spec     <= w_spec;
            r1_spec_s   <= w_spec_s;
            r1_spec_f   <= w_spec_f;
            r1_sign     <= w_s_big;
            r1_eff_sub  <= w_sa ^ w_sb;
            r1_both_neg <= w_sa & w_sb;
            r1_exp      <= w_e_big;
            r1_mb       <= {w_m_big, 3'b000};
            r1_ms       <= w_m_al;

            r2_spec   <= r1_spec;
            r2_spec_s <= r1_spec_s;
            r2_spec_f <= r1_spec_f;
            // Exact cancellation is +0 unless both inputs were negative zeros.
            r2_sign   <= (w_sum == '0) ? r1_both_neg : r1_sign;
            r2_exp    <= r1_exp;
            r2_sum    <= w_sum;

            r3_spec   <= r2_spec;
            r3_spec_s <= r2_spec_s;
            r3_spec_f <= r2_spec_f;
            r3_sign   <= r2_sign;
            r3_exp    <= w_n_exp;
            r3_mant   <= w_n_mant;
            r3_ftz    <= w_n_ftz;
        end
    end

endmodule

// File: tb/tb_fp_add_pipe.sv
// tb/tb_fp_add_pipe.sv - directed-vector bench for fp_add_pipe
module tb_fp_add_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        sub = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] s;
    logic [4:0]  flags;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        sub;
        logic [31:0] s;
        logic [4:0]  f;
        string       tag;
    } vec_t;

    vec_t vecs[$];

    fp_add_pipe dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s         (s),
        .flags     (flags)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic vec_t mk(input logic [31:0] va, input logic [31:0] vb, input logic vs,
                                input logic [31:0] vr, input logic [4:0] vf, input string t);
        vec_t v;
        v.a = va; v.b = vb; v.sub = vs; v.s = vr; v.f = vf; v.tag = t;
        return v;
    endfunction

    task automatic run_vec(input vec_t v);
        int cyc;
        a = v.a; b = v.b; sub = v.sub; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = $urandom(); b = $urandom(); sub = 1'($urandom());
        cyc = 0;
        while (cyc < 10) begin
            @(posedge clk); #1;
            cyc++;
            if (out_valid) break;
        end
        check({v.tag, "_lat"}, 64'(cyc), 64'd3);
        check({v.tag, "_s"}, 64'(s), 64'(v.s));
        check({v.tag, "_flags"}, 64'(flags), 64'(v.f));
    endtask

    initial begin
        int fed, got, stalls, late;

        // flags = {invalid, overflow, underflow, inexact, zero}
        vecs.push_back(mk(32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 5'b00000, "add_1_2"));
        vecs.push_back(mk(32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 5'b00001, "sub_1_1"));
        vecs.push_back(mk(32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 5'b00010, "rne_tie"));
        vecs.push_back(mk(32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, 5'b00010, "rne_up"));
        vecs.push_back(mk(32'h7F800000, 32'hFF800000, 1'b0, 32'h7FC00000, 5'b10000, "inf_ninf"));
        vecs.push_back(mk(32'h7FA00000, 32'h3F800000, 1'b0, 32'h7FC00000, 5'b00000, "snan"));
        vecs.push_back(mk(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 5'b01010, "ovf"));
        vecs.push_back(mk(32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 5'b00001, "nz_nz"));
        vecs.push_back(mk(32'hBF800000, 32'h3F800000, 1'b0, 32'h00000000, 5'b00001, "cancel"));
        vecs.push_back(mk(32'h3F800000, 32'h40000000, 1'b1, 32'hBF800000, 5'b00000, "neg_res"));
        vecs.push_back(mk(32'h3FC00000, 32'h7F800000, 1'b1, 32'hFF800000, 5'b00000, "inf_pass"));
        vecs.push_back(mk(32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 5'b10000, "inf_sub"));
`ifdef FP_ADD_PIPE_DENORM_EN
        vecs.push_back(mk(32'h00000001, 32'h00000001, 1'b0, 32'h00000002, 5'b00000, "sub_sub"));
        vecs.push_back(mk(32'h00800000, 32'h00000001, 1'b1, 32'h007FFFFF, 5'b00000, "min_norm"));
        vecs.push_back(mk(32'h00C00000, 32'h00800000, 1'b1, 32'h00400000, 5'b00000, "to_sub"));
`else
        vecs.push_back(mk(32'h00000001, 32'h00000001, 1'b0, 32'h00000000, 5'b00001, "sub_sub"));
        vecs.push_back(mk(32'h00800000, 32'h00000001, 1'b1, 32'h00800000, 5'b00000, "min_norm"));
        vecs.push_back(mk(32'h00C00000, 32'h00800000, 1'b1, 32'h00000000, 5'b00111, "to_sub"));
`endif

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_s", 64'(s), 64'd0);
        check("rst_flags", 64'(flags), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;

        foreach (vecs[i]) run_vec(vecs[i]);

        // back-to-back stream with a 5-cycle downstream stall
        fed = 0; got = 0; stalls = 0;
        for (int cyc = 0; cyc < 40 && got < 6; cyc++) begin
            @(posedge clk); #1;
            out_ready = !(cyc >= 5 && cyc < 10);
            if (fed < 6) begin
                a = vecs[fed].a; b = vecs[fed].b; sub = vecs[fed].sub; in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            if (out_valid && !out_ready) begin
                stalls++;
                check("bp_in_ready", 64'(in_ready), 64'd0);
                check("bp_hold_s", 64'(s), 64'(vecs[got].s));
                check("bp_hold_flags", 64'(flags), 64'(vecs[got].f));
            end
            if (out_valid && out_ready) begin
                check($sformatf("bp_s%0d", got), 64'(s), 64'(vecs[got].s));
                check($sformatf("bp_f%0d", got), 64'(flags), 64'(vecs[got].f));
                got++;
            end
            if (in_valid && in_ready) fed++;
        end
        @(posedge clk); #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("bp_count", 64'(got), 64'd6);
        check("bp_stalls", 64'(stalls), 64'd5);
        repeat (5) @(posedge clk);
        #1;

        // reset with three operations in flight
        for (int k = 0; k < 3; k++) begin
            a = vecs[k].a; b = vecs[k].b; sub = vecs[k].sub; in_valid = 1'b1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        check("rst_pre_valid", 64'(out_valid), 64'd1);
        #2 rst = 1'b1;
        #1;
        check("arst_out_valid", 64'(out_valid), 64'd0);
        check("arst_s", 64'(s), 64'd0);
        check("arst_flags", 64'(flags), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check("post_rst_in_ready", 64'(in_ready), 64'd1);
        late = 0;
        repeat (8) begin
            @(negedge clk);
            if (out_valid) late++;
        end
        check("post_rst_stale", 64'(late), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
